// File: rtl/i2c_wb_sequencer.sv
// Sequences I2C transactions on an iicmb_m_wb core over a Wishbone master port.
// Each byte command is followed by an irq wait and a CMDR status read.
module i2c_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int MAX_BYTES      = 16,
    parameter int BUS_W          = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int LEN_W = $clog2(MAX_BYTES + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_rw_i,
    input  logic [BUS_W-1:0]         req_bus_i,
    input  logic [6:0]               req_addr_i,
    input  logic [LEN_W-1:0]         req_len_i,
    input  logic                     wdata_valid_i,
    output logic                     wdata_ready_o,
    input  logic [7:0]               wdata_i,
    output logic                     rdata_valid_o,
    output logic [7:0]               rdata_o,
    output logic                     done_o,
    output logic [2:0]               status_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);
    localparam logic [2:0] ST_OK  = 3'b000;
    localparam logic [2:0] ST_NAK = 3'b001;
    localparam logic [2:0] ST_AL  = 3'b010;
    localparam logic [2:0] ST_ERR = 3'b011;
    localparam logic [2:0] ST_TMO = 3'b100;
    localparam logic [2:0] ST_LEN = 3'b101;

    typedef enum logic [4:0] {
        S_IDLE, S_CSR, S_BUS_D, S_BUS_C, S_START, S_ADR_D, S_ADR_C,
        S_WR_GET, S_WR_C, S_RD_C, S_RD_D, S_RD_NX, S_STOP,
        S_ACC, S_WAIT, S_CHK, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        P_BUS, P_START, P_ADDR, P_WR, P_RD, P_STOP
    } phase_t;

    state_t                   r_state, w_state, r_ret, w_ret;
    phase_t                   r_ph, w_ph;
    logic                     r_cyc, w_cyc, r_we, w_we;
    logic [WB_ADDR_WIDTH-1:0] r_adr, w_adr;
    logic [WB_DATA_WIDTH-1:0] r_dat, w_dat;
    logic                     r_en, w_en, r_bvld, w_bvld;
    logic [BUS_W-1:0]         r_bus, w_bus, r_breq, w_breq;
    logic                     r_rw, w_rw;
    logic [6:0]               r_addr, w_addr;
    logic [LEN_W-1:0]         r_len, w_len, r_cnt, w_cnt;
    logic [2:0]               r_status, w_status;
    logic                     r_done, w_done, r_rvld, w_rvld, r_wrdy, w_wrdy;
    logic                     r_ready, w_ready;
    logic [7:0]               r_rdata, w_rdata, r_rd, w_rd;
    logic [TW-1:0]            r_tmo, w_tmo;
    logic                     w_acc, w_rdacc, w_cmd, w_last, w_need;
    logic [7:0]               w_cdat;

    assign w_last = (LEN_W'(r_cnt + 1'b1) == r_len);
    assign w_need = !r_bvld || (r_bus != r_breq);

    always_comb begin
        w_state  = r_state;
        w_ret    = r_ret;
        w_ph     = r_ph;
        w_cyc    = r_cyc;
        w_we     = r_we;
        w_adr    = r_adr;
        w_dat    = r_dat;
        w_en     = r_en;
        w_bvld   = r_bvld;
        w_bus    = r_bus;
        w_breq   = r_breq;
        w_rw     = r_rw;
        w_addr   = r_addr;
        w_len    = r_len;
        w_cnt    = r_cnt;
        w_status = r_status;
        w_rvld   = 1'b0;
        w_rdata  = r_rdata;
        w_rd     = r_rd;
        w_tmo    = r_tmo;
        w_acc    = 1'b0;
        w_rdacc  = 1'b0;
        w_cmd    = 1'b0;
        w_cdat   = 8'h00;
        unique case (r_state)
            S_IDLE: if (req_valid_i && r_ready) begin
                w_rw     = req_rw_i;
                w_breq   = req_bus_i;
                w_addr   = req_addr_i;
                w_len    = req_len_i;
                w_cnt    = '0;
                w_status = ST_OK;
                if (req_len_i > LEN_W'(MAX_BYTES)) begin
                    w_status = ST_LEN;
                    w_state  = S_DONE;
                end else if (!r_en)
                    w_state = S_CSR;
                else if (!r_bvld || r_bus != req_bus_i)
                    w_state = S_BUS_D;
                else
                    w_state = S_START;
            end
            S_CSR: begin
                w_acc = 1'b1;
                w_en  = 1'b1;
                w_adr = A_CSR;
                w_dat = WB_DATA_WIDTH'(8'hC0);
                w_ret = w_need ? S_BUS_D : S_START;
            end
            S_BUS_D: begin
                w_acc = 1'b1;
                w_adr = A_DPR;
                w_dat = WB_DATA_WIDTH'(r_breq);
                w_ret = S_BUS_C;
            end
            S_BUS_C: begin
                w_cmd  = 1'b1;
                w_cdat = 8'h06;
                w_ph   = P_BUS;
                w_bvld = 1'b1;
                w_bus  = r_breq;
            end
            S_START: begin
                w_cmd  = 1'b1;
                w_cdat = 8'h04;
                w_ph   = P_START;
            end
            S_ADR_D: begin
                w_acc = 1'b1;
                w_adr = A_DPR;
                w_dat = WB_DATA_WIDTH'({r_addr, r_rw});
                w_ret = S_ADR_C;
            end
            S_ADR_C: begin
                w_cmd  = 1'b1;
                w_cdat = 8'h01;
                w_ph   = P_ADDR;
            end
            S_WR_GET: if (r_wrdy && wdata_valid_i) begin
                w_acc = 1'b1;
                w_adr = A_DPR;
                w_dat = WB_DATA_WIDTH'(wdata_i);
                w_ret = S_WR_C;
            end
            S_WR_C: begin
                w_cmd  = 1'b1;
                w_cdat = 8'h01;
                w_ph   = P_WR;
            end
            S_RD_C: begin
                w_cmd  = 1'b1;
                w_cdat = w_last ? 8'h03 : 8'h02;
                w_ph   = P_RD;
            end
            S_RD_D: begin
                w_acc   = 1'b1;
                w_rdacc = 1'b1;
                w_adr   = A_DPR;
                w_ret   = S_RD_NX;
            end
            S_RD_NX: begin
                w_cnt   = LEN_W'(r_cnt + 1'b1);
                w_state = w_last ? S_STOP : S_RD_C;
            end
            S_STOP: begin
                w_cmd  = 1'b1;
                w_cdat = 8'h05;
                w_ph   = P_STOP;
            end
            S_ACC: if (ack_i) begin
                w_cyc   = 1'b0;
                w_rd    = dat_i[7:0];
                w_state = r_ret;
                if (r_ret == S_RD_NX) begin
                    w_rvld  = 1'b1;
                    w_rdata = dat_i[7:0];
                end
            end
            S_WAIT: begin
                if (irq_i) begin
                    w_acc   = 1'b1;
                    w_rdacc = 1'b1;
                    w_adr   = A_CMDR;
                    w_ret   = S_CHK;
                end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_status = ST_TMO;
                    w_bvld   = 1'b0;
                    w_state  = S_DONE;
                end else
                    w_tmo = r_tmo + TW'(1);
            end
            // Status bits in priority order: ERR, AL, NAK, then DON.
            S_CHK: begin
                if (r_rd[4]) begin
                    w_status = ST_ERR;
                    w_state  = S_DONE;
                end else if (r_rd[5]) begin
                    w_status = ST_AL;
                    w_bvld   = 1'b0;
                    w_state  = S_DONE;
                end else if (r_rd[6]) begin
                    w_status = ST_NAK;
                    w_state  = (r_ph == P_STOP) ? S_DONE : S_STOP;
                end else begin
                    unique case (r_ph)
                        P_BUS:   w_state = S_START;
                        P_START: w_state = S_ADR_D;
                        P_ADDR:  w_state = (r_len == '0) ? S_STOP :
                                           (r_rw ? S_RD_C : S_WR_GET);
                        P_WR: begin
                            w_cnt   = LEN_W'(r_cnt + 1'b1);
                            w_state = w_last ? S_STOP : S_WR_GET;
                        end
                        P_RD:    w_state = S_RD_D;
                        default: w_state = S_DONE;
                    endcase
                end
            end
            S_DONE:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
        if (w_cmd) begin
            w_acc = 1'b1;
            w_adr = A_CMDR;
            w_dat = WB_DATA_WIDTH'(w_cdat);
            w_ret = S_WAIT;
        end
        if (w_acc) begin
            w_cyc   = 1'b1;
            w_we    = !w_rdacc;
            w_state = S_ACC;
        end
        if (w_state == S_WAIT && r_state != S_WAIT)
            w_tmo = '0;
        w_ready = (w_state == S_IDLE);
        w_done  = (w_state == S_DONE);
        w_wrdy  = (w_state == S_WR_GET);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_ret    <= S_IDLE;
            r_ph     <= P_BUS;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_en     <= 1'b0;
            r_bvld   <= 1'b0;
            r_bus    <= '0;
            r_breq   <= '0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_status <= ST_OK;
            r_done   <= 1'b0;
            r_rvld   <= 1'b0;
            r_rdata  <= '0;
            r_rd     <= '0;
            r_wrdy   <= 1'b0;
            r_ready  <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state;
            r_ret    <= w_ret;
            r_ph     <= w_ph;
            r_cyc    <= w_cyc;
            r_we     <= w_we;
            r_adr    <= w_adr;
            r_dat    <= w_dat;
            r_en     <= w_en;
            r_bvld   <= w_bvld;
            r_bus    <= w_bus;
            r_breq   <= w_breq;
            r_rw     <= w_rw;
            r_addr   <= w_addr;
            r_len    <= w_len;
            r_cnt    <= w_cnt;
            r_status <= w_status;
            r_done   <= w_done;
            r_rvld   <= w_rvld;
            r_rdata  <= w_rdata;
            r_rd     <= w_rd;
            r_wrdy   <= w_wrdy;
            r_ready  <= w_ready;
            r_tmo    <= w_tmo;
        end
    end

    assign req_ready_o   = r_ready;
    assign wdata_ready_o = r_wrdy;
    assign rdata_valid_o = r_rvld;
    assign rdata_o       = r_rdata;
    assign done_o        = r_done;
    assign status_o      = r_status;
    assign cyc_o         = r_cyc;
    assign stb_o         = r_cyc;
    assign we_o          = r_we;
    assign adr_o         = r_adr;
    assign dat_o         = r_dat;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Directed bench for i2c_wb_sequencer with a small iicmb-like Wishbone slave.
module tb_i2c_wb_sequencer;

    localparam int MAXB = 16;
    localparam int TMO  = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid_i = 1'b0, req_ready_o, req_rw_i = 1'b0;
    logic [3:0] req_bus_i = '0;
    logic [6:0] req_addr_i = '0;
    logic [4:0] req_len_i = '0;
    logic       wdata_valid_i = 1'b0, wdata_ready_o;
    logic [7:0] wdata_i = '0;
    logic       rdata_valid_o, done_o;
    logic [7:0] rdata_o;
    logic [2:0] status_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o, dat_i = '0;
    logic       ack_i, irq_i;

    always #5 clk = ~clk;

    i2c_wb_sequencer #(
        .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .MAX_BYTES(MAXB),
        .BUS_W(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rw_i(req_rw_i), .req_bus_i(req_bus_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wdata_i(wdata_i),
        .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
        .done_o(done_o), .status_o(status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
        .ack_i(ack_i), .irq_i(irq_i)
    );

    logic [10:0] wlog[$];
    logic [10:0] exp_q[$];
    logic [7:0]  cq[$], rdq[$], wq[$], rxq[$];
    bit          ack_hold = 0, irq_block = 0;
    int          done_cnt = 0, gap_viol = 0;
    logic        ackq = 1'b0;
    int          checks = 0, errors = 0;

    // Slave: one-cycle ack, irq raised by every CMDR write, cleared by CMDR read.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_i <= 1'b0;
            irq_i <= 1'b0;
        end else begin
            ack_i <= 1'b0;
            if (cyc_o && stb_o && !ack_i && !ack_hold) begin
                ack_i <= 1'b1;
                wlog.push_back({we_o, adr_o, we_o ? dat_o : 8'h00});
                if (!we_o && adr_o == 2'd2) begin
                    irq_i <= 1'b0;
                    if (cq.size() != 0) dat_i <= cq.pop_front();
                    else dat_i <= 8'h80;
                end else if (!we_o) begin
                    if (rdq.size() != 0) dat_i <= rdq.pop_front();
                    else dat_i <= 8'hEE;
                end else if (adr_o == 2'd2 && !irq_block)
                    irq_i <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (rdata_valid_o) rxq.push_back(rdata_o);
        if (done_o) done_cnt <= done_cnt + 1;
        if (ackq && cyc_o) gap_viol <= gap_viol + 1;
        ackq <= ack_i;
        if (wdata_ready_o && wdata_valid_i) void'(wq.pop_front());
    end

    always @(negedge clk) begin
        wdata_valid_i = (wq.size() != 0);
        wdata_i = (wq.size() != 0) ? wq[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
            $error("check %s differs", tag);
        end
    endtask

    task automatic ew(input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic cmd(input logic [7:0] d);
        exp_q.push_back({1'b1, 2'd2, d});
        exp_q.push_back({1'b0, 2'd2, 8'h00});
    endtask

    task automatic chk_log(input string tag);
        chk({tag, " wb count"}, wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            chk($sformatf("%s wb[%0d]", tag, i), wlog[i], exp_q[i]);
        wlog.delete();
        exp_q.delete();
    endtask

    task automatic req(input logic rw, input logic [3:0] bus,
                       input logic [6:0] addr, input logic [4:0] len);
        bit hs;
        hs = 0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_rw_i = rw;
        req_bus_i = bus;
        req_addr_i = addr;
        req_len_i = len;
        for (int i = 0; i < 200; i++) begin
            if (req_ready_o) begin
                hs = 1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        chk("req accepted", 32'(hs), 1);
    endtask

    task automatic wait_done(input string tag, input int base,
                             input logic [2:0] st);
        for (int i = 0; i < 500 && done_cnt == base; i++)
            @(negedge clk);
        chk({tag, " done pulses"}, done_cnt - base, 1);
        chk({tag, " status"}, 32'(status_o), 32'(st));
        repeat (3) @(negedge clk);
        chk({tag, " single done"}, done_cnt - base, 1);
    endtask

    initial begin
        int base;
        bit seen;

        #22;
        chk("rst cyc", 32'(cyc_o), 0);
        chk("rst ready", 32'(req_ready_o), 0);
        chk("rst done", 32'(done_o), 0);
        chk("rst status", 32'(status_o), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready before edge", 32'(req_ready_o), 0);
        @(negedge clk);
        chk("ready after edge", 32'(req_ready_o), 1);

        base = done_cnt;
        wq.push_back(8'h78);
        ew(2'd0, 8'hC0); ew(2'd1, 8'h00); cmd(8'h06); cmd(8'h04);
        ew(2'd1, 8'h44); cmd(8'h01); ew(2'd1, 8'h78); cmd(8'h01);
        cmd(8'h05);
        req(1'b0, 4'd0, 7'h22, 5'd1);
        wait_done("first write", base, 3'b000);
        chk_log("first write");

        base = done_cnt;
        rdq.push_back(8'hA5);
        rdq.push_back(8'h5A);
        cmd(8'h04); ew(2'd1, 8'h45); cmd(8'h01);
        cmd(8'h02); exp_q.push_back({1'b0, 2'd1, 8'h00});
        cmd(8'h03); exp_q.push_back({1'b0, 2'd1, 8'h00});
        cmd(8'h05);
        req(1'b1, 4'd0, 7'h22, 5'd2);
        wait_done("read", base, 3'b000);
        chk_log("read");
        chk("read bytes", rxq.size(), 2);
        if (rxq.size() == 2) begin
            chk("read byte0", 32'(rxq[0]), 32'hA5);
            chk("read byte1", 32'(rxq[1]), 32'h5A);
        end
        rxq.delete();

        base = done_cnt;
        cq.push_back(8'h80);
        cq.push_back(8'h40);
        cmd(8'h04); ew(2'd1, 8'h44); cmd(8'h01); cmd(8'h05);
        req(1'b0, 4'd0, 7'h22, 5'd2);
        wait_done("nak", base, 3'b001);
        chk_log("nak");

        base = done_cnt;
        cq.push_back(8'h20);
        cmd(8'h04);
        req(1'b0, 4'd0, 7'h22, 5'd1);
        wait_done("arb lost", base, 3'b010);
        chk_log("arb lost");

        base = done_cnt;
        ew(2'd1, 8'h00); cmd(8'h06); cmd(8'h04);
        ew(2'd1, 8'h44); cmd(8'h01); cmd(8'h05);
        req(1'b0, 4'd0, 7'h22, 5'd0);
        wait_done("probe", base, 3'b000);
        chk_log("probe");

        base = done_cnt;
        irq_block = 1;
        ew(2'd2, 8'h04);
        req(1'b0, 4'd0, 7'h22, 5'd1);
        wait_done("timeout", base, 3'b100);
        chk("timeout cyc", 32'(cyc_o), 0);
        chk_log("timeout");
        irq_block = 0;

        base = done_cnt;
        req(1'b0, 4'd0, 7'h22, 5'd17);
        @(negedge clk);
        chk("bad len done timing", 32'(done_o), 1);
        wait_done("bad len", base, 3'b101);
        chk_log("bad len");

        base = done_cnt;
        ack_hold = 1;
        seen = 0;
        req(1'b0, 4'd3, 7'h10, 5'd1);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = cyc_o;
        end
        chk("reset cyc seen", 32'(seen), 1);
        rst = 1'b1;
        #1;
        chk("async cyc", 32'(cyc_o), 0);
        chk("async stb", 32'(stb_o), 0);
        chk("async done", 32'(done_o), 0);
        chk("async ready", 32'(req_ready_o), 0);
        @(negedge clk);
        ack_hold = 0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abandoned done", done_cnt - base, 0);
        wlog.delete();

        base = done_cnt;
        wq.push_back(8'h11);
        ew(2'd0, 8'hC0); ew(2'd1, 8'h03); cmd(8'h06); cmd(8'h04);
        ew(2'd1, 8'h20); cmd(8'h01); ew(2'd1, 8'h11); cmd(8'h01);
        cmd(8'h05);
        req(1'b0, 4'd3, 7'h10, 5'd1);
        wait_done("after reset", base, 3'b000);
        chk_log("after reset");

        chk("cyc gap", gap_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
